sync_controller: RTL and testbench
==================================

SYNC_CONTROLLER -- requirements
Module: sync_controller

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 10000000, clocks per local second.
REQ-002 SHALL have parameter HDR, default 8'hA5, frame header byte.
REQ-003 SHALL have parameter BYTE_TO, default 20000, maximum clocks allowed between frame bytes.
REQ-004 SHALL have parameter LOST_SEC, default 3, seconds without a valid frame before sync is declared lost.
REQ-005 SHALL have one clock and a synchronous active-high reset: clk_10M and rst.
REQ-006 clk_10M  input  1  system clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rx_valid  input  1  one-cycle strobe from the UART receiver; rx_byte is valid in that cycle.
REQ-009 rx_byte  input  8  received byte.
REQ-010 syn_set  output  1  one-cycle pulse on acceptance of a valid sync frame.
REQ-011 syn_time  output  8  time value of the last accepted frame.
REQ-012 time_second  output  8  local seconds counter.
REQ-013 sec_tick  output  1  one-cycle pulse on each local second boundary.
REQ-014 load_ready  output  1  one-cycle slot strobe granting the slave-data load.
REQ-015 sync_lost  output  1  level; high when not synchronised.
REQ-016 frame_err  output  1  one-cycle pulse on a checksum or timeout error.

Function
REQ-017 The frame SHALL be three bytes: HDR, T, C, where C = HDR ^ T.
REQ-018 The frame FSM SHALL have states IDLE, GOT_HDR and GOT_TIME.
- IDLE: on rx_valid with rx_byte==HDR, go to GOT_HDR. Ignore all other bytes without error.
- GOT_HDR: on rx_valid, latch T and go to GOT_TIME.
- GOT_TIME: on rx_valid, compare the byte with HDR^T. On a match, accept the frame. On a mismatch, pulse frame_err. Either way, return to IDLE.
REQ-019 The inter-byte counter SHALL clear on every rx_valid while in GOT_HDR or GOT_TIME, and SHALL count while in those states.
- When the count reaches BYTE_TO without a new byte, pulse frame_err and return to IDLE.
- If rx_valid arrives in the same cycle as the timeout, the byte wins and no error is raised.
REQ-020 On acceptance, in the cycle after the checksum strobe:
- pulse syn_set;
- load syn_time and time_second with T;
- clear the prescaler to 0;
- clear sync_lost;
- clear the lost-second counter.
REQ-021 The prescaler SHALL count 0..CLK_PER_SEC-1. On wrap, it SHALL pulse sec_tick and increment time_second modulo 256 (255 wraps to 0).
REQ-022 If frame acceptance and a prescaler wrap occur in the same cycle, acceptance SHALL win: no sec_tick, and time_second=T.
REQ-023 Each sec_tick SHALL increment the lost-second counter, which saturates at LOST_SEC. When the counter reaches LOST_SEC, sync_lost SHALL be set on the same edge.
REQ-024 load_ready SHALL pulse in the same cycle as sec_tick only if sync_lost is 0 before that edge's update. It SHALL never pulse while sync_lost is 1.
REQ-025 syn_set, sec_tick, load_ready and frame_err SHALL each be at most one cycle wide. No output SHALL be combinationally dependent on its inputs.
REQ-026 A HDR byte received in GOT_HDR SHALL be treated as T. Frames SHALL NOT resynchronise mid-frame.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter this state:
- FSM in IDLE;
- all counters 0;
- syn_set=0, syn_time=0, time_second=0;
- sec_tick=0, load_ready=0, frame_err=0;
- sync_lost=1.
REQ-028 Reset asserted mid-frame or mid-second SHALL abandon the frame with no frame_err pulse, and SHALL restart the prescaler from 0.
REQ-029 The first sec_tick after reset release SHALL occur CLK_PER_SEC cycles later.

Verification (CLK_PER_SEC=10, BYTE_TO=20, LOST_SEC=3)
REQ-030 Valid frame: bytes A5, 07, A2 -> syn_set=1 for one cycle, one cycle after the A2 strobe; syn_time=7; time_second=7; sync_lost=0. Then 10 clocks later: sec_tick=1, load_ready=1, time_second=8.
REQ-031 Bad checksum: bytes A5, 07, 00 -> frame_err pulses once; syn_set stays 0; time_second unchanged.
REQ-032 Inter-byte timeout: byte A5, then silence for 20 clocks -> frame_err pulses; FSM returns to IDLE. A following A5, 01, A4 is then accepted.
REQ-033 Loss of sync: after an accepted frame, no further frames for 3 seconds -> sync_lost rises on the 3rd sec_tick. load_ready pulses on the 1st and 2nd ticks only.
REQ-034 Wrap and collision:
- a frame with T=FF, followed by 1 s -> time_second=00.
- a checksum strobe timed so that acceptance lands on the prescaler-wrap cycle -> no sec_tick; time_second=T.
REQ-035 Reset mid-frame: rst asserted after byte 07 of A5, 07, A2 -> all outputs at reset values; no syn_set; sync_lost=1.

Source files
------------

// File: rtl/sync_controller.sv
// Time-sync frame receiver and local seconds keeper.
// Parses three-byte frames (HDR, T, HDR^T) from a UART byte stream, keeps a
// local seconds counter that is re-anchored on every accepted frame, and
// tracks loss of synchronisation when frames stop arriving.
module sync_controller #(
  parameter int         CLK_PER_SEC = 10000000,
  parameter logic [7:0] HDR         = 8'hA5,
  parameter int         BYTE_TO     = 20000,
  parameter int         LOST_SEC    = 3
) (
  input  logic       clk_10M,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       syn_set,
  output logic [7:0] syn_time,
  output logic [7:0] time_second,
  output logic       sec_tick,
  output logic       load_ready,
  output logic       sync_lost,
  output logic       frame_err
);

  localparam int PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam int CNT_W   = $clog2(BYTE_TO + 1);
  localparam int LOST_W  = $clog2(LOST_SEC + 1);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_SEC - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(BYTE_TO - 1);
  localparam logic [LOST_W-1:0]  LOST_MAX  = LOST_W'(LOST_SEC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_HDR  = 2'd1,
    GOT_TIME = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [7:0]          t_latch;
  logic [CNT_W-1:0]    byte_cnt;
  logic [PRESC_W-1:0]  presc;
  logic [LOST_W-1:0]   lost_cnt;
  logic [LOST_W-1:0]   lost_nxt;

  // Decode results of the current cycle, consumed by the output registers.
  logic                accept_p0;
  logic                cs_err_p0;
  logic                timeout_p0;
  logic                byte_to_hit;
  logic                wrap_p0;
  logic                lost_reach;

  // Saturating increment for the seconds-without-frame counter.
  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    logic [LOST_W-1:0] r;
    r = v;
    if (v != LOST_MAX) begin
      r = v + LOST_W'(1);
    end
    return r;
  endfunction

  assign byte_to_hit = (byte_cnt == CNT_MAX);
  assign wrap_p0     = (presc == PRESC_MAX);
  assign lost_nxt    = sat_inc(lost_cnt);
  assign lost_reach  = (lost_nxt == LOST_MAX);

  // Frame FSM state register.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame FSM next state plus accept / checksum-error / timeout decode.
  // A byte arriving on the timeout cycle takes priority over the timeout.
  always_comb begin
    state_nxt  = state;
    accept_p0  = 1'b0;
    cs_err_p0  = 1'b0;
    timeout_p0 = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && (rx_byte == HDR)) begin
          state_nxt = GOT_HDR;
        end
      end
      GOT_HDR: begin
        if (rx_valid) begin
          state_nxt = GOT_TIME;
        end else if (byte_to_hit) begin
          timeout_p0 = 1'b1;
          state_nxt  = IDLE;
        end
      end
      GOT_TIME: begin
        if (rx_valid) begin
          state_nxt = IDLE;
          if (rx_byte == (HDR ^ t_latch)) begin
            accept_p0 = 1'b1;
          end else begin
            cs_err_p0 = 1'b1;
          end
        end else if (byte_to_hit) begin
          timeout_p0 = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Inter-byte silence counter, live only while a frame is in progress.
  always_ff @(posedge clk_10M) begin
    if (rst || rx_valid || (state == IDLE) || timeout_p0) begin
      byte_cnt <= '0;
    end else begin
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Time byte capture; any byte in GOT_HDR (including HDR itself) is T.
  always_ff @(posedge clk_10M) begin
    if (state == GOT_HDR && rx_valid) begin
      t_latch <= rx_byte;
    end
  end

  // Error pulse and acceptance pulse, one cycle after the deciding strobe.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      syn_set   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      syn_set   <= accept_p0;
      frame_err <= cs_err_p0 | timeout_p0;
    end
  end

  // Accepted time value.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      syn_time <= 8'd0;
    end else if (accept_p0) begin
      syn_time <= t_latch;
    end
  end

  // Prescaler and seconds counter; acceptance re-anchors both and
  // suppresses a coincident wrap.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      presc       <= '0;
      time_second <= 8'd0;
      sec_tick    <= 1'b0;
    end else if (accept_p0) begin
      presc       <= '0;
      time_second <= t_latch;
      sec_tick    <= 1'b0;
    end else if (wrap_p0) begin
      presc       <= '0;
      time_second <= time_second + 8'd1;
      sec_tick    <= 1'b1;
    end else begin
      presc       <= presc + PRESC_W'(1);
      sec_tick    <= 1'b0;
    end
  end

  // Loss-of-sync tracking and the slave-data load slot. The slot is withheld
  // on the tick that declares sync lost so it never coincides with sync_lost.
  always_ff @(posedge clk_10M) begin
    if (rst) begin
      lost_cnt   <= '0;
      sync_lost  <= 1'b1;
      load_ready <= 1'b0;
    end else if (accept_p0) begin
      lost_cnt   <= '0;
      sync_lost  <= 1'b0;
      load_ready <= 1'b0;
    end else if (wrap_p0) begin
      lost_cnt   <= lost_nxt;
      load_ready <= ~sync_lost & ~lost_reach;
      if (lost_reach) begin
        sync_lost <= 1'b1;
      end
    end else begin
      load_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_controller.sv
// Bench for sync_controller: directed byte streams, a per-cycle reference
// model of the frame/seconds rules, and literal spot checks.
module tb_sync_controller;

  localparam int         CPS  = 10;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         BTO  = 20;
  localparam int         LOST = 3;

  logic       clk_10M = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       syn_set, sec_tick, load_ready, sync_lost, frame_err;
  logic [7:0] syn_time, time_second;

  int checks = 0;
  int failures = 0;

  sync_controller #(
    .CLK_PER_SEC(CPS),
    .HDR(HDR),
    .BYTE_TO(BTO),
    .LOST_SEC(LOST)
  ) dut (
    .clk_10M(clk_10M),
    .rst(rst),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .syn_set(syn_set),
    .syn_time(syn_time),
    .time_second(time_second),
    .sec_tick(sec_tick),
    .load_ready(load_ready),
    .sync_lost(sync_lost),
    .frame_err(frame_err)
  );

  always #50 clk_10M = ~clk_10M;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit         m_on = 0;
  logic [7:0] fq[$];
  int         silent;
  int         since;
  int         lost_secs;
  int         e_syn_set, e_frame_err, e_tick, e_load, e_lost;
  int         e_syn_time, e_time;

  task automatic model_step();
    int acc;
    int t;
    if (rst) begin
      m_on = 1;
      fq.delete();
      silent = 0; since = 0; lost_secs = 0;
      e_syn_set = 0; e_frame_err = 0; e_tick = 0; e_load = 0; e_lost = 1;
      e_syn_time = 0; e_time = 0;
      return;
    end
    if (!m_on) return;
    acc = 0; t = 0;
    e_syn_set = 0; e_frame_err = 0; e_tick = 0; e_load = 0;
    if (rx_valid) begin
      silent = 0;
      if (fq.size() == 0) begin
        if (rx_byte == HDR) fq.push_back(rx_byte);
      end else if (fq.size() == 1) begin
        fq.push_back(rx_byte);
      end else begin
        if (rx_byte == (fq[0] ^ fq[1])) begin
          acc = 1; t = fq[1];
        end else begin
          e_frame_err = 1;
        end
        fq.delete();
      end
    end else if (fq.size() > 0) begin
      silent++;
      if (silent == BTO) begin
        e_frame_err = 1;
        fq.delete();
        silent = 0;
      end
    end
    if (acc) begin
      since = 0;
      e_syn_set = 1; e_syn_time = t; e_time = t;
      lost_secs = 0; e_lost = 0;
    end else begin
      since++;
      if (since % CPS == 0) begin
        e_tick = 1;
        e_time = (e_time + 1) % 256;
        if (lost_secs < LOST) lost_secs++;
        if (lost_secs == LOST) e_lost = 1;
        e_load = (e_lost == 0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk_10M);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk_10M);
    if (m_on) begin
      chk("m_syn_set", int'(syn_set), e_syn_set);
      chk("m_syn_time", int'(syn_time), e_syn_time);
      chk("m_time_second", int'(time_second), e_time);
      chk("m_sec_tick", int'(sec_tick), e_tick);
      chk("m_load_ready", int'(load_ready), e_load);
      chk("m_sync_lost", int'(sync_lost), e_lost);
      chk("m_frame_err", int'(frame_err), e_frame_err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk_10M);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_10M);
  endtask

  initial begin
    @(negedge clk_10M);
    idle(2);
    chk("rst_sync_lost", int'(sync_lost), 1);
    chk("rst_time_second", int'(time_second), 0);
    chk("rst_syn_time", int'(syn_time), 0);
    chk("rst_syn_set", int'(syn_set), 0);
    rst = 1'b0;

    // Valid frame
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'hA2);
    chk("vf_syn_set", int'(syn_set), 1);
    chk("vf_syn_time", int'(syn_time), 7);
    chk("vf_time", int'(time_second), 7);
    chk("vf_sync_lost", int'(sync_lost), 0);
    idle(1);
    chk("vf_syn_set_width", int'(syn_set), 0);
    idle(9);
    chk("vf_tick", int'(sec_tick), 1);
    chk("vf_load", int'(load_ready), 1);
    chk("vf_time8", int'(time_second), 8);

    // Bad checksum
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00);
    chk("bc_frame_err", int'(frame_err), 1);
    chk("bc_syn_set", int'(syn_set), 0);
    chk("bc_time", int'(time_second), 8);
    idle(1);
    chk("bc_err_width", int'(frame_err), 0);

    // Inter-byte timeout, then a good frame
    send_byte(8'hA5);
    idle(19);
    chk("to_not_yet", int'(frame_err), 0);
    idle(1);
    chk("to_frame_err", int'(frame_err), 1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA4);
    chk("to_accept", int'(syn_set), 1);
    chk("to_time", int'(time_second), 1);

    // Loss of sync over three silent seconds
    idle(10);
    chk("ls_t1_load", int'(load_ready), 1);
    chk("ls_t1_lost", int'(sync_lost), 0);
    idle(10);
    chk("ls_t2_load", int'(load_ready), 1);
    chk("ls_t2_lost", int'(sync_lost), 0);
    idle(10);
    chk("ls_t3_tick", int'(sec_tick), 1);
    chk("ls_t3_load", int'(load_ready), 0);
    chk("ls_t3_lost", int'(sync_lost), 1);
    chk("ls_t3_time", int'(time_second), 4);

    // Wrap FF -> 00
    send_byte(8'hA5); send_byte(8'hFF); send_byte(8'h5A);
    chk("wr_syn_time", int'(syn_time), 8'hFF);
    idle(10);
    chk("wr_tick", int'(sec_tick), 1);
    chk("wr_time", int'(time_second), 0);

    // Acceptance on the prescaler wrap cycle
    idle(7);
    send_byte(8'hA5); send_byte(8'h33); send_byte(8'h96);
    chk("col_syn_set", int'(syn_set), 1);
    chk("col_no_tick", int'(sec_tick), 0);
    chk("col_time", int'(time_second), 8'h33);
    idle(10);
    chk("col_next_tick", int'(sec_tick), 1);
    chk("col_next_time", int'(time_second), 8'h34);

    // HDR byte used as T
    send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h00);
    chk("hh_syn_set", int'(syn_set), 1);
    chk("hh_syn_time", int'(syn_time), 8'hA5);

    // Reset mid-frame
    send_byte(8'hA5); send_byte(8'h07);
    rst = 1'b1;
    idle(2);
    chk("rm_syn_time", int'(syn_time), 0);
    chk("rm_time", int'(time_second), 0);
    chk("rm_sync_lost", int'(sync_lost), 1);
    chk("rm_frame_err", int'(frame_err), 0);
    rst = 1'b0;
    send_byte(8'hA2);
    chk("rm_no_syn_set", int'(syn_set), 0);
    chk("rm_no_err", int'(frame_err), 0);
    idle(8);
    chk("rm_tick_early", int'(sec_tick), 0);
    idle(1);
    chk("rm_first_tick", int'(sec_tick), 1);
    chk("rm_no_load", int'(load_ready), 0);

    // Byte on the timeout cycle wins
    send_byte(8'hA5);
    idle(19);
    send_byte(8'h07);
    chk("tb_no_err", int'(frame_err), 0);
    send_byte(8'hA2);
    chk("tb_accept", int'(syn_set), 1);
    chk("tb_syn_time", int'(syn_time), 7);

    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
